// File: rtl/spi_master_param.sv
// Parameterised SPI master: SPI modes 0-3, NUM_CS chip selects, LSB- or MSB-first framing.
// Receive capture into dout is built only when SPI_MASTER_RX_EN is defined; otherwise dout stays 0.
module spi_master_param #(
    parameter int unsigned  DATA_W    = 12,
    parameter int unsigned  CLK_DIV   = 10,
    parameter int unsigned  NUM_CS    = 1,
    parameter int unsigned  MSB_FIRST = 0,
    localparam int unsigned CS_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic [1:0]        mode,
    input  logic              miso,
    output logic              sclk,
    output logic              mosi,
    output logic [NUM_CS-1:0] cs_n,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] dout
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);
    localparam int unsigned HP_W  = $clog2(2 * DATA_W);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [HP_W-1:0]     hp, hp_nxt;
    logic [DATA_W-1:0]   tx_sh, tx_nxt;
    logic [1:0]          mode_q, mode_nxt;
    logic                sclk_nxt, mosi_nxt, busy_nxt, done_nxt;
    logic [NUM_CS-1:0]   cs_n_nxt;
    logic [DATA_W-1:0]   dout_nxt;
    logic                tick, lead, trail, accept;

    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
        return (MSB_FIRST != 0) ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
    endfunction

    // Out-of-range selects decode to no active line.
    function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
        logic [NUM_CS-1:0] v;
        v = '1;
        for (int unsigned i = 0; i < NUM_CS; i++) begin
            if (sel == CS_W'(i)) v[i] = 1'b0;
        end
        return v;
    endfunction

`ifdef SPI_MASTER_RX_EN
    logic [DATA_W-1:0] rx_sh, rx_nxt;

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b);
        return (MSB_FIRST != 0) ? {w[DATA_W-2:0], b} : {b, w[DATA_W-1:1]};
    endfunction
`else
    logic unused_miso;
    assign unused_miso = miso;
`endif

    assign tick = (cnt == CNT_W'(CLK_DIV - 1));

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            hp     <= '0;
            tx_sh  <= '0;
            mode_q <= '0;
            sclk   <= 1'b0;
            mosi   <= 1'b0;
            cs_n   <= '1;
            busy   <= 1'b0;
            done   <= 1'b0;
            dout   <= '0;
`ifdef SPI_MASTER_RX_EN
            rx_sh  <= '0;
`endif
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            hp     <= hp_nxt;
            tx_sh  <= tx_nxt;
            mode_q <= mode_nxt;
            sclk   <= sclk_nxt;
            mosi   <= mosi_nxt;
            cs_n   <= cs_n_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
            dout   <= dout_nxt;
`ifdef SPI_MASTER_RX_EN
            rx_sh  <= rx_nxt;
`endif
        end
    end

    // Next-state: sequencing, sclk edges, shift/sample and accept (also in the final HOLD cycle).
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hp_nxt    = hp;
        tx_nxt    = tx_sh;
        mode_nxt  = mode_q;
        sclk_nxt  = sclk;
        mosi_nxt  = mosi;
        cs_n_nxt  = cs_n;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        dout_nxt  = dout;
        lead      = 1'b0;
        trail     = 1'b0;
        accept    = 1'b0;
`ifdef SPI_MASTER_RX_EN
        rx_nxt    = rx_sh;
`endif

        if (state != IDLE) cnt_nxt = tick ? '0 : cnt + CNT_W'(1);

        case (state)
            IDLE: begin
                mosi_nxt = 1'b0;
                sclk_nxt = mode_q[1];
                accept   = start;
            end
            SETUP: begin
                if (tick) begin
                    state_nxt = XFER;
                    hp_nxt    = '0;
                    lead      = 1'b1;
                end
            end
            XFER: begin
                if (tick) begin
                    if (hp == HP_W'(2 * DATA_W - 1)) begin
                        state_nxt = HOLD;
                    end else begin
                        hp_nxt = hp + HP_W'(1);
                        lead   = hp[0];
                        trail  = ~hp[0];
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    cs_n_nxt  = '1;
                    mosi_nxt  = 1'b0;
`ifdef SPI_MASTER_RX_EN
                    dout_nxt  = rx_sh;
`endif
                    accept    = start;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (lead)  sclk_nxt = ~mode_q[1];
        if (trail) sclk_nxt = mode_q[1];

        // CPHA=0 shifts on trailing edges, CPHA=1 on leading edges; sampling uses the other edge.
        if ((lead && mode_q[0]) || (trail && !mode_q[0])) begin
            mosi_nxt = first_bit(tx_sh);
            tx_nxt   = shift_out(tx_sh);
        end
`ifdef SPI_MASTER_RX_EN
        if ((lead && !mode_q[0]) || (trail && mode_q[0])) rx_nxt = shift_in(rx_sh, miso);
`endif

        if (accept) begin
            state_nxt = SETUP;
            cnt_nxt   = '0;
            hp_nxt    = '0;
            mode_nxt  = mode;
            busy_nxt  = 1'b1;
            sclk_nxt  = mode[1];
            cs_n_nxt  = cs_decode(cs_sel);
            mosi_nxt  = mode[0] ? 1'b0 : first_bit(din);
            tx_nxt    = mode[0] ? din : shift_out(din);
`ifdef SPI_MASTER_RX_EN
            rx_nxt    = '0;
`endif
        end
    end

endmodule

// File: tb/tb_spi_master_param.sv
// Scoreboard bench for spi_master_param: an LSB-first 4-CS instance and an MSB-first 3-CS instance
// run the same transfers with miso looped to their own mosi (or forced high).
module tb_spi_master_param;

    typedef struct {
        int unsigned due;
        logic [11:0] din;
        logic [1:0]  mode;
        logic [1:0]  sel;
        bit          forced;
    } ent_t;

    logic        clk, rst, start, miso_force;
    logic [11:0] din;
    logic [1:0]  cs_sel, mode;
    logic        miso_a, sclk_a, mosi_a, busy_a, done_a;
    logic        miso_b, sclk_b, mosi_b, busy_b, done_b;
    logic [3:0]  cs_n_a;
    logic [2:0]  cs_n_b;
    logic [11:0] dout_a, dout_b;

    int unsigned n_cmp = 0, n_err = 0, cyc = 0, n_done = 0;
    ent_t        sb[$];

    // Monitor accumulators for the transfer at the head of the scoreboard.
    logic        prev_busy, prev_done, prev_sclk_a, prev_sclk_b, seen_b, first_b;
    logic [11:0] word_a, word_b;
    int unsigned rises_a, low_a, low_b, bad_cs;

    assign miso_a = miso_force ? 1'b1 : mosi_a;
    assign miso_b = miso_force ? 1'b1 : mosi_b;

    spi_master_param #(.DATA_W(12), .CLK_DIV(4), .NUM_CS(4), .MSB_FIRST(0)) u_dut (
        .clk(clk), .rst(rst), .start(start), .din(din), .cs_sel(cs_sel), .mode(mode),
        .miso(miso_a), .sclk(sclk_a), .mosi(mosi_a), .cs_n(cs_n_a), .busy(busy_a),
        .done(done_a), .dout(dout_a)
    );

    spi_master_param #(.DATA_W(12), .CLK_DIV(4), .NUM_CS(3), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .start(start), .din(din), .cs_sel(cs_sel), .mode(mode),
        .miso(miso_b), .sclk(sclk_b), .mosi(mosi_b), .cs_n(cs_n_b), .busy(busy_b),
        .done(done_b), .dout(dout_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_acc();
        word_a = '0; word_b = '0; rises_a = 0; low_a = 0; low_b = 0; bad_cs = 0;
        seen_b = 1'b0; first_b = 1'b0;
    endtask

    function automatic logic [3:0] exp_csa(input logic [1:0] s);
        return ~(4'b0001 << s);
    endfunction

    function automatic logic [2:0] exp_csb(input logic [1:0] s);
        return (s == 2'd3) ? 3'b111 : ~(3'b001 << s);
    endfunction

    // Monitor: rebuild transmitted words from sclk/mosi, count cs_n low time, check at done.
    always @(negedge clk) begin
        ent_t        e;
        logic [11:0] ed;
        if (rst) begin
            clear_acc();
            prev_busy = 1'b0; prev_done = 1'b0;
            prev_sclk_a = sclk_a; prev_sclk_b = sclk_b;
        end else begin
            if (done_a) begin
                n_done++;
                check("done_b_align", 32'(done_b), 32'd1);
                if (sb.size() == 0) begin
                    check("spurious_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
`ifdef SPI_MASTER_RX_EN
                    ed = e.forced ? 12'hFFF : e.din;
`else
                    ed = 12'h000;
`endif
                    check("done_time", cyc, e.due);
                    check("dout_lsb", 32'(dout_a), 32'(ed));
                    check("dout_msb", 32'(dout_b), 32'(ed));
                    check("tx_word_lsb", 32'(word_a), 32'(e.din));
                    check("tx_word_msb", 32'(word_b), 32'(e.din));
                    check("first_bit_msb", 32'(first_b), 32'(e.din[11]));
                    check("sclk_rises", rises_a, 32'd12);
                    check("cs_low_lsb", low_a, 32'd104);
                    check("cs_low_msb", low_b, (e.sel == 2'd3) ? 32'd0 : 32'd104);
                    check("cs_pattern", bad_cs, 32'd0);
                end
                clear_acc();
            end
            if (sb.size() != 0) begin
                e = sb[0];
                if (prev_busy && !prev_done) begin
                    if (sclk_a != prev_sclk_a) begin
                        if (sclk_a) rises_a++;
                        if ((sclk_a != e.mode[1]) == !e.mode[0]) word_a = {mosi_a, word_a[11:1]};
                    end
                    if (sclk_b != prev_sclk_b) begin
                        if (!seen_b) begin
                            seen_b  = 1'b1;
                            first_b = mosi_b;
                        end
                        if ((sclk_b != e.mode[1]) == !e.mode[0]) word_b = {word_b[10:0], mosi_b};
                    end
                end
                if (cs_n_a != 4'hF) begin
                    low_a++;
                    if (cs_n_a != exp_csa(e.sel)) bad_cs++;
                end
                if (cs_n_b != 3'h7) begin
                    low_b++;
                    if (cs_n_b != exp_csb(e.sel)) bad_cs++;
                end
            end
            prev_busy = busy_a; prev_done = done_a;
            prev_sclk_a = sclk_a; prev_sclk_b = sclk_b;
        end
    end

    task automatic push(input int unsigned due, input logic [11:0] d, input logic [1:0] m,
                        input logic [1:0] s);
        ent_t e;
        e.due = due; e.din = d; e.mode = m; e.sel = s; e.forced = miso_force;
        sb.push_back(e);
    endtask

    // One transfer from idle; inputs are scrambled right after accept.
    task automatic xfer(input logic [11:0] d, input logic [1:0] m, input logic [1:0] s,
                        output int unsigned t_acc);
        @(negedge clk);
        din = d; mode = m; cs_sel = s; start = 1'b1;
        @(posedge clk); #1;
        t_acc = cyc;
        push(cyc + 104, d, m, s);
        start = 1'b0; din = ~d; mode = ~m; cs_sel = s + 2'd1;
    endtask

    task automatic drain(input int unsigned budget);
        int unsigned n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t0, snap;
        rst = 1'b1; start = 1'b1; din = 12'hA5C; mode = 2'b00; cs_sel = 2'd0; miso_force = 1'b0;
        clear_acc();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cs_n_lsb", 32'(cs_n_a), 32'hF);
        check("rst_cs_n_msb", 32'(cs_n_b), 32'h7);
        check("rst_sclk", 32'(sclk_a), 32'd0);
        check("rst_mosi", 32'(mosi_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_dout", 32'(dout_a), 32'd0);

        // Start already high when reset falls: accepted on the first edge.
        rst = 1'b0;
        @(posedge clk); #1;
        push(cyc + 104, 12'hA5C, 2'b00, 2'd0);
        start = 1'b0; din = 12'h3FF; mode = 2'b11; cs_sel = 2'd3;
        repeat (20) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain(300);
        check("idle_busy", 32'(busy_a), 32'd0);
        check("idle_sclk_cpol0", 32'(sclk_a), 32'd0);

        xfer(12'h801, 2'b11, 2'd1, t0);
        drain(300);
        check("idle_sclk_cpol1_lsb", 32'(sclk_a), 32'd1);
        check("idle_sclk_cpol1_msb", 32'(sclk_b), 32'd1);
        check("idle_mosi", 32'(mosi_b), 32'd0);

        xfer(12'h3C7, 2'b01, 2'd2, t0);
        drain(300);
        xfer(12'h5A0, 2'b10, 2'd3, t0);
        drain(300);

        miso_force = 1'b1;
        xfer(12'h0F0, 2'b00, 2'd0, t0);
        drain(300);
        miso_force = 1'b0;

        // Back-to-back: start held high through done.
        @(negedge clk);
        din = 12'h6E1; mode = 2'b01; cs_sel = 2'd0; start = 1'b1;
        @(posedge clk); #1;
        t0 = cyc;
        push(t0 + 104, 12'h6E1, 2'b01, 2'd0);
        push(t0 + 208, 12'h19B, 2'b01, 2'd1);
        din = 12'h19B; cs_sel = 2'd1;
        while (cyc < t0 + 104) @(negedge clk);
        check("b2b_done", 32'(done_a), 32'd1);
        check("b2b_busy", 32'(busy_a), 32'd1);
        start = 1'b0;
        drain(400);

        // Asynchronous reset in the middle of a mode-3 transfer.
        xfer(12'hABC, 2'b11, 2'd0, t0);
        while (cyc < t0 + 50) @(negedge clk);
        check("pre_rst_sclk", 32'(sclk_a), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_cs_n_lsb", 32'(cs_n_a), 32'hF);
        check("arst_cs_n_msb", 32'(cs_n_b), 32'h7);
        check("arst_sclk", 32'(sclk_a), 32'd0);
        check("arst_busy", 32'(busy_a), 32'd0);
        check("arst_mosi", 32'(mosi_a), 32'd0);
        check("arst_dout", 32'(dout_a), 32'd0);
        sb.delete();
        snap = n_done;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (150) @(negedge clk);
        check("no_done_after_rst", n_done, snap);

        xfer(12'h123, 2'b00, 2'd1, t0);
        drain(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_master_param.md
SPI_MASTER_PARAM -- requirements
Module: spi_master_param

Interface
REQ-001 SHALL have parameter DATA_W, default 12, the bits per transfer (minimum 2).
REQ-002 SHALL have parameter CLK_DIV, default 10, the clk cycles per sclk half-period (minimum 2).
REQ-003 SHALL have parameter NUM_CS, default 1, the number of chip-select lines (1..8).
REQ-004 SHALL have parameter MSB_FIRST, default 0, where 1 shifts the MSB first and 0 shifts the LSB first.
REQ-005 SHALL have port clk, input, 1 bit, the single system clock; all logic on posedge.
REQ-006 SHALL have port rst, input, 1 bit, the reset, asynchronous and active-high.
REQ-007 SHALL have port start, input, 1 bit, the transfer request, sampled in IDLE only.
REQ-008 SHALL have port din, input, DATA_W bits, the transmit word, latched on accept.
REQ-009 SHALL have port cs_sel, input, max(1,$clog2(NUM_CS)) bits, the target select, latched on accept.
REQ-010 SHALL have port mode, input, 2 bits, {CPOL,CPHA}, latched on accept.
REQ-011 SHALL have port miso, input, 1 bit, the serial receive data.
REQ-012 SHALL have port sclk, output, 1 bit, the serial clock.
REQ-013 SHALL have port mosi, output, 1 bit, the serial transmit data.
REQ-014 SHALL have port cs_n, output, NUM_CS bits, the active-low chip selects.
REQ-015 SHALL have port busy, output, 1 bit, high from accept until done.
REQ-016 SHALL have port done, output, 1 bit, a one-clk completion pulse.
REQ-017 SHALL have port dout, output, DATA_W bits, the received word.

Function
REQ-018 SHALL implement the states IDLE, SETUP, XFER and HOLD, each timed by a half-period divider counting 0..CLK_DIV-1, cleared on accept.
REQ-019 SHALL accept a transfer when start=1 in IDLE: latch din/cs_sel/mode, set busy=1, drive sclk=CPOL, enter SETUP.
REQ-020 SHALL, in SETUP, drive cs_n[cs_sel]=0 for one half-period; if CPHA=0, mosi carries the first bit for the whole of SETUP.
REQ-021 SHALL, in XFER, generate DATA_W sclk pulses (2*DATA_W half-periods), where CPHA=0 samples miso on the leading edge and shifts mosi on the trailing edge, and CPHA=1 shifts on the leading edge and samples on the trailing edge.
REQ-022 SHALL, in HOLD, keep sclk=CPOL and cs_n asserted for one half-period, then deassert all cs_n, pulse done, set busy=0, and return to IDLE.
REQ-023 SHALL assert done exactly (2*DATA_W+2)*CLK_DIV clk cycles after the accepting edge.
REQ-024 SHALL, with MSB_FIRST=0, send din[0] first; with MSB_FIRST=1, send din[DATA_W-1] first; received bits fill in the same order.
REQ-025 SHALL ignore start while busy=1; a start asserted in the cycle done=1 SHALL be accepted (back-to-back transfers).
REQ-026 SHALL, when cs_sel>=NUM_CS, assert no cs_n line but still run the full transfer timing.
REQ-027 SHALL hold mosi=0 and sclk=CPOL of the last transfer whenever in IDLE.
REQ-028 SHALL keep din/mode/cs_sel changes during a transfer from affecting that transfer.

Reset
REQ-029 SHALL, on rst=1 at any time including mid-transfer, immediately force state=IDLE, sclk=0, mosi=0, cs_n=all 1, busy=0, done=0, dout=0, and clear the divider and bit counter.
REQ-030 SHALL start no transfer while rst=1; the first accept is possible on the first clk edge after rst falls.

Configuration
REQ-031 SHALL, with macro SPI_MASTER_RX_EN defined, shift miso into a receive register and load dout with the received word on the cycle done=1, holding it until the next done.
REQ-032 SHALL, without SPI_MASTER_RX_EN, keep port miso present but ignored and hold dout at 0; all other behaviour is identical.

Verification
REQ-033 SHALL cover: DATA_W=12, CLK_DIV=4, mode=0, din=12'hA5C, miso looped to mosi -> done at cycle 104 after accept, dout=12'hA5C, 12 sclk rising edges.
REQ-034 SHALL cover: mode=3, MSB_FIRST=1, din=12'h801 -> sclk idles high, first mosi bit 1 set on the first falling edge, cs_n low for 26 half-periods.
REQ-035 SHALL cover: NUM_CS=4, cs_sel=2 -> only cs_n[2] low; cs_sel=5 with NUM_CS=5 invalid config avoided; cs_sel=3 with NUM_CS=3 -> cs_n stays all 1 and done still at cycle 104.
REQ-036 SHALL cover: start held high across done -> second transfer accepted in the done cycle, busy low for 0 cycles, 2 done pulses 104 cycles apart.
REQ-037 SHALL cover: rst pulsed at cycle 50 of a transfer -> cs_n=all 1, sclk=0, busy=0 asynchronously, no done pulse.
REQ-038 SHALL cover: build without SPI_MASTER_RX_EN and miso=1 throughout -> dout=0 after done.
